speed_gate_dp: RTL and testbench

Multi-lane speed-trap and gate datapath: per-lane millisecond timers between two sensors, a shared sequential divider converting elapsed time to speed, a saturating occupancy counter, and barrier-enable control. Generalises the single-lane gate datapath to `LANES` lanes with a bounded occupancy count, per-lane timeout, and a flagged divide-by-zero result. It sits between the sensor/debounce front end and the gate controller FSM / display logic.

---
 rtl/speed_gate_dp.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_speed_gate_dp.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_gate_dp.sv
// speed_gate_dp: multi-lane speed trap and gate datapath.
// Each lane times the interval between its two sensors in milliseconds. A shared
// restoring divider turns that time into speed = SPEED_K / ms. Alongside sit a
// saturating occupancy counter and the barrier-enable latch.
// Optional feature: define SPEED_GATE_OVERSPEED_EN to build the overspeed comparator.

module speed_gate_lane #(
    parameter int WIDTH_MS = 9
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ms_tick,
    input  logic                sensor_a,
    input  logic                sensor_b,
    input  logic                grant,
    output logic                pend,
    output logic [WIDTH_MS-1:0] ms,
    output logic                timeout
);
    typedef enum logic [1:0] {IDLE, TIMING, PEND} lane_state_e;

    localparam logic [WIDTH_MS-1:0] MS_MAX = '1;

    lane_state_e         state_q, state_d;
    logic [WIDTH_MS-1:0] ms_q, ms_d;
    logic                timeout_q, timeout_d;

    // Lane state, elapsed-ms counter and registered timeout pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ms_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ms_q      <= ms_d;
            timeout_q <= timeout_d;
        end
    end

    // Start on A, stop on B (B beats a coincident tick), abandon on counter wrap
    always_comb begin
        state_d   = state_q;
        ms_d      = ms_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sensor_a) begin
                    state_d = TIMING;
                    ms_d    = '0;
                end
            end
            TIMING: begin
                if (sensor_b) begin
                    state_d = PEND;
                end else if (ms_tick) begin
                    if (ms_q == MS_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ms_d = ms_q + 1'b1;
                    end
                end
            end
            PEND: begin
                if (grant) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pend    = (state_q == PEND);
    assign ms      = ms_q;
    assign timeout = timeout_q;
endmodule

module speed_gate_dp #(
    parameter int LANES       = 2,
    parameter int CLK_PER_MS  = 50000,
    parameter int WIDTH_MS    = 9,
    parameter int WIDTH_SPEED = 14,
    parameter int SPEED_K     = 14400,
    parameter int CAPACITY    = 3,
    parameter int WIDTH_CNT   = 2,
    parameter int SPEED_LIMIT = 60,
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [LANES-1:0]       sensor_a,
    input  logic [LANES-1:0]       sensor_b,
    input  logic                   veh_in,
    input  logic                   veh_out,
    input  logic                   bar_open,
    input  logic                   bar_close,
    output logic [WIDTH_CNT-1:0]   num_veh,
    output logic                   full,
    output logic                   empty,
    output logic [WIDTH_SPEED-1:0] speed,
    output logic [LANE_W-1:0]      speed_lane,
    output logic                   speed_valid,
    output logic                   div_zero,
    output logic [LANES-1:0]       timeout,
    output logic                   overspeed,
    output logic                   en_barrier
);
    localparam int WS   = WIDTH_SPEED;
    localparam int PS_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int IT_W = $clog2(WIDTH_SPEED + 1);
    localparam logic [WIDTH_CNT-1:0] CAP_C = WIDTH_CNT'(CAPACITY);

    // Reject parameter sets the datapath cannot represent
    if (CAPACITY >= (1 << WIDTH_CNT) || LANES < 1 || LANES > 8 ||
        WIDTH_MS > WIDTH_SPEED || SPEED_K >= (1 << WIDTH_SPEED) ||
        SPEED_LIMIT >= (1 << WIDTH_SPEED)) begin : g_bad_cfg
        $error("speed_gate_dp: inconsistent parameter set");
    end

    // ---------------- millisecond prescaler ----------------
    logic [PS_W-1:0] ps_q, ps_d;
    logic            ms_tick;

    assign ms_tick = (ps_q == PS_W'(CLK_PER_MS - 1));

    // Free-running prescaler, wraps at CLK_PER_MS-1
    always_comb begin
        ps_d = ms_tick ? '0 : ps_q + 1'b1;
    end

    // ---------------- lanes ----------------
    logic [LANES-1:0]               lane_pend;
    logic [LANES-1:0]               gnt;
    logic [LANES-1:0][WIDTH_MS-1:0] lane_ms;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        speed_gate_lane #(.WIDTH_MS(WIDTH_MS)) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .ms_tick  (ms_tick),
            .sensor_a (sensor_a[g]),
            .sensor_b (sensor_b[g]),
            .grant    (gnt[g]),
            .pend     (lane_pend[g]),
            .ms       (lane_ms[g]),
            .timeout  (timeout[g])
        );
    end

    // ---------------- round-robin arbiter ----------------
    logic [LANE_W-1:0]   last_q, last_d;
    logic [LANE_W-1:0]   gnt_lane;
    logic                gnt_vld;
    logic [WIDTH_MS-1:0] gnt_ms;
    logic                busy_q, busy_d;
    int                  idx;

    // Pick the first pending lane after the last one served, only while the divider is free
    always_comb begin
        gnt      = '0;
        gnt_lane = '0;
        gnt_vld  = 1'b0;
        gnt_ms   = '0;
        idx      = 0;
        if (!busy_q) begin
            for (int i = 1; i <= LANES; i++) begin
                idx = int'(last_q) + i;
                if (idx >= LANES) idx = idx - LANES;
                if (!gnt_vld && lane_pend[idx]) begin
                    gnt_vld  = 1'b1;
                    gnt_lane = LANE_W'(idx);
                    gnt_ms   = lane_ms[idx];
                    gnt[idx] = 1'b1;
                end
            end
        end
        last_d = gnt_vld ? gnt_lane : last_q;
    end

    // ---------------- restoring divider ----------------
    // The dividend register doubles as the quotient: each step shifts the next
    // dividend bit out of the top and the fresh quotient bit in at the bottom.
    logic [IT_W-1:0]   iter_q, iter_d;
    logic [WS-1:0]     rem_q, rem_d;
    logic [WS-1:0]     dvd_q, dvd_d;
    logic [WS-1:0]     dsr_q, dsr_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WS:0]       rem_sh;
    logic              fits;
    logic [WS-1:0]     q_fin;

    logic [WS-1:0]     speed_q, speed_d;
    logic [LANE_W-1:0] speed_lane_q, speed_lane_d;
    logic              valid_q, valid_d;
    logic              dz_q, dz_d;
    logic              ovs_q, ovs_d;

    assign rem_sh = {rem_q, dvd_q[WS-1]};
    assign fits   = (rem_sh >= {1'b0, dsr_q});
    assign q_fin  = {dvd_q[WS-2:0], fits};

    // Divider sequencing and result capture; a zero divisor bypasses the iterations
    always_comb begin
        busy_d       = busy_q;
        iter_d       = iter_q;
        rem_d        = rem_q;
        dvd_d        = dvd_q;
        dsr_d        = dsr_q;
        lane_d       = lane_q;
        speed_d      = speed_q;
        speed_lane_d = speed_lane_q;
        valid_d      = 1'b0;
        dz_d         = 1'b0;
        ovs_d        = 1'b0;
        if (busy_q) begin
            rem_d = fits ? WS'(rem_sh - {1'b0, dsr_q}) : WS'(rem_sh);
            dvd_d = q_fin;
            if (iter_q == '0) begin
                busy_d       = 1'b0;
                valid_d      = 1'b1;
                speed_d      = q_fin;
                speed_lane_d = lane_q;
`ifdef SPEED_GATE_OVERSPEED_EN
                ovs_d        = (q_fin > WS'(SPEED_LIMIT));
`else
                ovs_d        = 1'b0;
`endif
            end else begin
                iter_d = iter_q - 1'b1;
            end
        end else if (gnt_vld) begin
            lane_d = gnt_lane;
            if (gnt_ms == '0) begin
                valid_d      = 1'b1;
                dz_d         = 1'b1;
                speed_d      = '1;
                speed_lane_d = gnt_lane;
            end else begin
                busy_d = 1'b1;
                iter_d = IT_W'(WIDTH_SPEED - 1);
                rem_d  = '0;
                dvd_d  = WS'(SPEED_K);
                dsr_d  = WS'(gnt_ms);
            end
        end
    end

    // ---------------- occupancy and barrier ----------------
    logic [WIDTH_CNT-1:0] num_q, num_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 bar_q, bar_d;
    logic                 acc_in, acc_out;

    // Saturating count; simultaneous in/out cancels. Flags follow the new count.
    always_comb begin
        acc_in  = veh_in && !veh_out && (num_q != CAP_C);
        acc_out = veh_out && !veh_in && (num_q != '0);
        num_d   = num_q;
        if (acc_in)  num_d = num_q + 1'b1;
        if (acc_out) num_d = num_q - 1'b1;
        full_d  = (num_d == CAP_C);
        empty_d = (num_d == '0);
        bar_d   = bar_q;
        if (acc_in || bar_open) bar_d = 1'b1;
        else if (bar_close)     bar_d = 1'b0;
    end

    // All state registers; every output reads 0 while reset is held
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ps_q         <= '0;
            last_q       <= LANE_W'(LANES - 1);
            busy_q       <= 1'b0;
            iter_q       <= '0;
            rem_q        <= '0;
            dvd_q        <= '0;
            dsr_q        <= '0;
            lane_q       <= '0;
            speed_q      <= '0;
            speed_lane_q <= '0;
            valid_q      <= 1'b0;
            dz_q         <= 1'b0;
            ovs_q        <= 1'b0;
            num_q        <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b0;
            bar_q        <= 1'b0;
        end else begin
            ps_q         <= ps_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            iter_q       <= iter_d;
            rem_q        <= rem_d;
            dvd_q        <= dvd_d;
            dsr_q        <= dsr_d;
            lane_q       <= lane_d;
            speed_q      <= speed_d;
            speed_lane_q <= speed_lane_d;
            valid_q      <= valid_d;
            dz_q         <= dz_d;
            ovs_q        <= ovs_d;
            num_q        <= num_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            bar_q        <= bar_d;
        end
    end

    assign num_veh     = num_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign en_barrier  = bar_q;
    assign speed       = speed_q;
    assign speed_lane  = speed_lane_q;
    assign speed_valid = valid_q;
    assign div_zero    = dz_q;
    assign overspeed   = ovs_q;
endmodule

// File: tb/tb_speed_gate_dp.sv
// Self-checking bench for speed_gate_dp: randomized sensor and vehicle traffic
// checked against a behavioural model of the lane/occupancy rules.
module tb_speed_gate_dp;
    localparam int LANES = 2, CPM = 10, WMS = 9, WSP = 14, K = 14400;
    localparam int CAP = 3, WCNT = 2, LIMIT = 60, LW = 1;
    localparam int MSMAX = (1 << WMS) - 1;
`ifdef SPEED_GATE_OVERSPEED_EN
    localparam bit OVS_EN = 1'b1;
`else
    localparam bit OVS_EN = 1'b0;
`endif

    logic             clk = 1'b0, reset_n = 1'b0;
    logic [LANES-1:0] sensor_a = '0, sensor_b = '0;
    logic             veh_in = 1'b0, veh_out = 1'b0, bar_open = 1'b0, bar_close = 1'b0;
    logic [WCNT-1:0]  num_veh;
    logic             full, empty, speed_valid, div_zero, overspeed, en_barrier;
    logic [WSP-1:0]   speed;
    logic [LW-1:0]    speed_lane;
    logic [LANES-1:0] timeout;

    int checks = 0, failures = 0;

    speed_gate_dp #(.LANES(LANES), .CLK_PER_MS(CPM), .WIDTH_MS(WMS), .WIDTH_SPEED(WSP),
                    .SPEED_K(K), .CAPACITY(CAP), .WIDTH_CNT(WCNT), .SPEED_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n), .sensor_a(sensor_a), .sensor_b(sensor_b),
        .veh_in(veh_in), .veh_out(veh_out), .bar_open(bar_open), .bar_close(bar_close),
        .num_veh(num_veh), .full(full), .empty(empty), .speed(speed), .speed_lane(speed_lane),
        .speed_valid(speed_valid), .div_zero(div_zero), .timeout(timeout),
        .overspeed(overspeed), .en_barrier(en_barrier));

    always #5 clk = ~clk;

    wire [WSP+LW+1:0] got = {speed, speed_lane, div_zero, overspeed};

    // Behavioural lane model: 0 idle, 1 timing, 2 waiting for its result
    int  cyc = 0, pcnt = 0;
    int  m_state [LANES], m_ms [LANES], m_bms [LANES], m_to_cyc [LANES];
    wire m_tick = (pcnt == CPM - 1);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            pcnt <= 0;
            for (int l = 0; l < LANES; l++) begin m_state[l] <= 0; m_ms[l] <= 0; end
        end else begin
            pcnt <= m_tick ? 0 : pcnt + 1;
            for (int l = 0; l < LANES; l++) begin
                if (m_state[l] == 0) begin
                    if (sensor_a[l]) begin m_state[l] <= 1; m_ms[l] <= 0; end
                end else if (m_state[l] == 1) begin
                    if (sensor_b[l]) begin
                        m_state[l] <= 2; m_bms[l] <= m_ms[l];
                    end else if (m_tick) begin
                        if (m_ms[l] == MSMAX) begin m_state[l] <= 0; m_to_cyc[l] <= cyc; end
                        else m_ms[l] <= m_ms[l] + 1;
                    end
                end else if (speed_valid && int'(speed_lane) == l) begin
                    m_state[l] <= 0;
                end
            end
        end
    end

    // Expected {speed, lane, div_zero, overspeed} from the arithmetic definition
    function automatic logic [WSP+LW+1:0] exp_res(input int ms, input int lane);
        int sp; bit dz, ov;
        dz = (ms == 0);
        sp = dz ? (1 << WSP) - 1 : K / ms;
        ov = OVS_EN && !dz && (sp > LIMIT);
        return {sp[WSP-1:0], lane[LW-1:0], dz, ov};
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse(input logic [LANES-1:0] a, input logic [LANES-1:0] b);
        sensor_a = a; sensor_b = b;
        step();
        sensor_a = '0; sensor_b = '0;
    endtask

    // Called one cycle after the stop pulse; lat = k means speed_valid in cycle N+k
    task automatic wait_result(input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (speed_valid) begin lat = k; break; end
            step();
        end
    endtask

    task automatic wait_ms(input int l, input int target, input int budget);
        int k;
        k = 0;
        while (m_ms[l] != target && k < budget) begin step(); k++; end
        if (m_ms[l] != target) begin
            checks++; failures++;
            $display("FAIL wait_ms lane=%0d ms=%0d target=%0d", l, m_ms[l], target);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; step(); reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({num_veh, full, empty, speed, speed_lane, speed_valid, div_zero, timeout, overspeed, en_barrier} !== '0) begin
            failures++; $display("FAIL reset_outputs got=%0h required=0",
                {num_veh, full, empty, speed, speed_lane, speed_valid, div_zero, timeout, overspeed, en_barrier});
        end
        reset_n = 1'b1;
        repeat (2) step();
        checks++;
        if ({num_veh, full, empty, en_barrier} !== {2'd0, 1'b0, 1'b1, 1'b0}) begin
            failures++; $display("FAIL reset_release_flags got=%b required=00010", {num_veh, full, empty, en_barrier});
        end
    endtask

    task automatic test_speed_basic();
        int lat; logic [WSP+LW+1:0] e;
        pulse(2'b01, 2'b00);
        wait_ms(0, 100, 1500);
        pulse(2'b00, 2'b01);
        e = exp_res(m_bms[0], 0);
        wait_result(40, lat);
        checks++; if (lat !== WSP + 2) begin failures++; $display("FAIL basic_latency got=%0d required=%0d", lat, WSP + 2); end
        checks++; if (got !== e) begin failures++; $display("FAIL basic_result got=%0h required=%0h", got, e); end
        @(posedge clk); @(negedge clk);
        checks++; if (speed_valid !== 1'b0) begin failures++; $display("FAIL basic_single_pulse got=%b required=0", speed_valid); end
        step();
    endtask

    task automatic test_div_zero();
        int lat;
        pulse(2'b01, 2'b00);
        pulse(2'b00, 2'b01);
        wait_result(10, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL zero_latency got=%0d required=2", lat); end
        checks++; if (got !== exp_res(0, 0)) begin failures++; $display("FAIL zero_result got=%0h required=%0h", got, exp_res(0, 0)); end
        @(posedge clk); @(negedge clk);
        checks++; if (speed_valid !== 1'b0) begin failures++; $display("FAIL zero_single_pulse got=%b required=0", speed_valid); end
        step();
    endtask

    task automatic test_back_to_back();
        int lat; logic [WSP+LW+1:0] e0, e1;
        do_reset();
        pulse(2'b10, 2'b00);
        wait_ms(1, 150, 2000);
        pulse(2'b01, 2'b00);
        wait_ms(0, 50, 1000);
        pulse(2'b00, 2'b11);
        e0 = exp_res(m_bms[0], 0);
        e1 = exp_res(m_bms[1], 1);
        wait_result(40, lat);
        checks++; if (lat !== WSP + 2) begin failures++; $display("FAIL b2b_first_latency got=%0d required=%0d", lat, WSP + 2); end
        checks++; if (got !== e0) begin failures++; $display("FAIL b2b_first_result got=%0h required=%0h", got, e0); end
        step();
        wait_result(40, lat);
        checks++; if (lat !== WSP + 1) begin failures++; $display("FAIL b2b_second_gap got=%0d required=%0d", lat, WSP + 1); end
        checks++; if (got !== e1) begin failures++; $display("FAIL b2b_second_result got=%0h required=%0h", got, e1); end
        step();
    endtask

    task automatic test_round_robin();
        int lat;
        pulse(2'b01, 2'b00);
        pulse(2'b00, 2'b01);
        wait_result(10, lat);
        step();
        pulse(2'b11, 2'b00);
        pulse(2'b00, 2'b11);
        wait_result(10, lat);
        checks++; if (lat !== 2 || got !== exp_res(0, 1)) begin
            failures++; $display("FAIL rr_first lat=%0d got=%0h required lat=2 res=%0h", lat, got, exp_res(0, 1));
        end
        step();
        wait_result(10, lat);
        checks++; if (lat !== 1 || got !== exp_res(0, 0)) begin
            failures++; $display("FAIL rr_second lat=%0d got=%0h required lat=1 res=%0h", lat, got, exp_res(0, 0));
        end
        step();
    endtask

    task automatic test_timeout();
        int pulses, sv, val, pcyc, lat;
        pulses = 0; sv = 0; val = 0; pcyc = -1;
        pulse(2'b10, 2'b00);
        for (int k = 0; k < (MSMAX + 1) * CPM + 100; k++) begin
            @(negedge clk);
            if (timeout !== '0) begin pulses++; val = int'(timeout); pcyc = cyc; end
            if (speed_valid) sv++;
            step();
        end
        checks++; if (pulses !== 1 || val !== 2) begin failures++; $display("FAIL timeout_pulse count=%0d value=%0d required count=1 value=2", pulses, val); end
        checks++; if (pcyc !== m_to_cyc[1] + 1) begin failures++; $display("FAIL timeout_cycle got=%0d required=%0d", pcyc, m_to_cyc[1] + 1); end
        checks++; if (sv !== 0) begin failures++; $display("FAIL timeout_no_result got=%0d required=0", sv); end
        pulse(2'b10, 2'b00);
        pulse(2'b00, 2'b10);
        wait_result(10, lat);
        checks++; if (lat !== 2 || got !== exp_res(0, 1)) begin
            failures++; $display("FAIL timeout_lane_idle lat=%0d got=%0h required lat=2 res=%0h", lat, got, exp_res(0, 1));
        end
        step();
    endtask

    task automatic test_random_speed();
        int l, n, lat, elat; logic [WSP+LW+1:0] e;
        for (int it = 0; it < 8; it++) begin
            l = $urandom_range(0, LANES - 1);
            pulse(LANES'(1) << l, '0);
            n = $urandom_range(0, 3000);
            for (int k = 0; k < n; k++) begin
                sensor_a = ($urandom_range(0, 15) == 0) ? (LANES'(1) << l) : '0;
                sensor_b = ($urandom_range(0, 15) == 0) ? ~(LANES'(1) << l) : '0;
                step();
            end
            sensor_a = '0; sensor_b = '0;
            pulse('0, LANES'(1) << l);
            e = exp_res(m_bms[l], l);
            elat = (m_bms[l] == 0) ? 2 : WSP + 2;
            wait_result(40, lat);
            checks++; if (lat !== elat || got !== e) begin
                failures++; $display("FAIL random_speed it=%0d lat=%0d got=%0h required lat=%0d res=%0h", it, lat, got, elat, e);
            end
            repeat (2) step();
        end
    endtask

    task automatic test_reset_mid();
        int sv;
        sv = 0;
        pulse(2'b01, 2'b00);
        repeat (30) step();
        pulse(2'b00, 2'b01);
        repeat (5) step();
        do_reset();
        repeat (40) begin
            @(negedge clk);
            if (speed_valid) sv++;
            step();
        end
        checks++; if (sv !== 0 || got !== '0) begin failures++; $display("FAIL reset_mid_division strobes=%0d res=%0h required 0 and 0", sv, got); end
    endtask

    task automatic test_occupancy();
        logic [3:0] dir [14];
        logic [3:0] s;
        int occ, bar; bit ai, ao;
        logic [4:0] e;
        dir = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b1000, 4'b1100,
                4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0011, 4'b0001, 4'b1100};
        occ = 0; bar = 0;
        for (int i = 0; i < 214; i++) begin
            if (i < 14) s = dir[i];
            else s = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0)};
            {veh_in, veh_out, bar_open, bar_close} = s;
            @(posedge clk);
            ai = s[3] && !s[2] && occ < CAP;
            ao = s[2] && !s[3] && occ > 0;
            occ = occ + int'(ai) - int'(ao);
            if (ai || s[1]) bar = 1; else if (s[0]) bar = 0;
            e = {occ[WCNT-1:0], occ == CAP, occ == 0, bar[0]};
            @(negedge clk);
            checks++; if ({num_veh, full, empty, en_barrier} !== e) begin
                failures++; $display("FAIL occupancy step=%0d got=%b required=%b", i, {num_veh, full, empty, en_barrier}, e);
            end
        end
        {veh_in, veh_out, bar_open, bar_close} = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_speed_basic();
        test_div_zero();
        test_back_to_back();
        test_round_robin();
        test_timeout();
        test_random_speed();
        test_reset_mid();
        test_occupancy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
